// File: rtl/uart_receiver.sv
// uart_receiver: 8-bit asynchronous serial receiver.
//
// Frame: one start bit (low), 8 data bits LSB first, an optional even-parity
// bit, then one stop bit (high). The line idles high.
//
// The raw RX input is resynchronised through two flops. Every decision uses
// the synchronised copy (rx_s). A 16-bit bit-timer places each sample near
// the middle of its bit:
//   - the start bit is confirmed half a bit after the falling edge;
//   - every later bit is sampled one full bit period after the previous one.
//
// Valid, Frame_Err and Parity_Err are registered one-cycle strobes. At most
// one of them fires per frame.
//
// Optional feature, selected at compile time:
//   UART_RX_PARITY_EN - adds a PARITY state that samples one even-parity bit
//                       between data bit 7 and the stop bit. When undefined,
//                       Parity_Err is tied low and the frame is 10 bits.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] Data,
    output logic       Valid,
    output logic       Frame_Err,
    output logic       Parity_Err,
    output logic       Busy
);

    // Timer compare points: middle of the start bit, and one full bit period.
    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;
`endif

    state_t      state;
    state_t      state_next;

    logic        rx_meta;
    logic        rx_s;
    logic [15:0] timer;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;

    // Control strobes decoded by the FSM for the datapath registers.
    logic        timer_clr;
    logic        bit_en;
    logic        load_data;
    logic        frame_hit;
    logic        parity_hit;

`ifdef UART_RX_PARITY_EN
    logic        par_sample;
    logic        par_bad;
`endif

    // Two-flop synchronizer. It resets to idle-high, so releasing reset
    // never looks like a start bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and datapath controls. The timer is cleared on every
    // transition, and it is held at zero while waiting for the line.
    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        bit_en     = 1'b0;
        load_data  = 1'b0;
        frame_hit  = 1'b0;
        parity_hit = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample = 1'b0;
`endif
        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (timer == HALF_CNT) begin
                    timer_clr  = 1'b1;
                    // A line already back high at mid-start is a glitch.
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == FULL_CNT) begin
                    timer_clr = 1'b1;
                    bit_en    = 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (timer == FULL_CNT) begin
                    timer_clr  = 1'b1;
                    par_sample = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (timer == FULL_CNT) begin
                    timer_clr = 1'b1;
                    if (rx_s) begin
                        // A bad stop bit takes priority over a parity error.
`ifdef UART_RX_PARITY_EN
                        if (par_bad) begin
                            parity_hit = 1'b1;
                        end else begin
                            load_data = 1'b1;
                        end
`else
                        load_data = 1'b1;
`endif
                        state_next = IDLE;
                    end else begin
                        frame_hit  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line returns high, so that a break
                // condition cannot retrigger reception.
                timer_clr = 1'b1;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                timer_clr  = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Bit-timer: free-runs inside a frame and restarts on each sample point.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            timer <= 16'd0;
        end else if (timer_clr) begin
            timer <= 16'd0;
        end else begin
            timer <= timer + 16'd1;
        end
    end

    // Bit counter and shift register. The counter restarts at each start bit
    // and saturates at 7 instead of wrapping.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if (state == START) begin
                bit_cnt <= 3'd0;
            end else if (bit_en && (bit_cnt != 3'd7)) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (bit_en) begin
                shift[bit_cnt] <= rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the received parity bit must equal the XOR of the data
    // bits. The result is held until the stop decision.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bad <= 1'b0;
        end else if (state == START) begin
            par_bad <= 1'b0;
        end else if (par_sample) begin
            par_bad <= (rx_s != ^shift);
        end
    end
`endif

    // Output register and strobes. Data only changes on a clean frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Data      <= 8'h00;
            Valid     <= 1'b0;
            Frame_Err <= 1'b0;
        end else begin
            Valid     <= load_data;
            Frame_Err <= frame_hit;
            if (load_data) begin
                Data <= shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity error strobe, raised at the stop decision.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Parity_Err <= 1'b0;
        end else begin
            Parity_Err <= parity_hit;
        end
    end
`else
    assign Parity_Err = parity_hit;
`endif

    assign Busy = (state != IDLE);

endmodule
